// File: rtl/bcd_event_counter_if.sv
// Control and display bundle between the user-input front end and bcd_event_counter.
`timescale 1ns/1ps
interface bcd_event_counter_if #(
  parameter int unsigned DIGITS = 2,
  parameter int unsigned BIN_W  = 8
) ();
  localparam int unsigned BCD_W = 4 * DIGITS;
  localparam int unsigned HEX_W = 7 * DIGITS;

  logic             clear;
  logic             enable;
  logic             down;
  logic             event_in;
  logic [BCD_W-1:0] bcd;
  logic [BIN_W-1:0] count;
  logic [HEX_W-1:0] hex;
  logic             limit;

  modport master (
    output clear, enable, down, event_in,
    input  bcd, count, hex, limit
  );

  modport slave (
    input  clear, enable, down, event_in,
    output bcd, count, hex, limit
  );
endinterface

// File: rtl/bcd_event_counter.sv
// Up/down BCD event counter with binary shadow count and per-digit active-low HEX drive.
// Define LEADING_ZERO_BLANK_EN to blank leading zero digits on the display.
`timescale 1ns/1ps
module bcd_event_counter #(
  parameter int unsigned DIGITS   = 2,
  parameter int unsigned BIN_W    = 8,
  parameter bit          SATURATE = 1'b0
) (
  input logic             clk,
  input logic             reset,
  bcd_event_counter_if.slave bus
);
  localparam int unsigned BCD_W = 4 * DIGITS;
  localparam int unsigned HEX_W = 7 * DIGITS;

  logic             prev;
  logic [BCD_W-1:0] bcd_q;
  logic [BIN_W-1:0] count_q;
  logic             limit_q;

  logic             step_c;
  logic [BCD_W-1:0] bcd_step_c;
  logic             at_max_c;
  logic             at_min_c;
  logic             at_limit_c;
  logic             hold_c;
  logic [HEX_W-1:0] hex_c;

  function automatic logic [6:0] seg7(input logic [3:0] nib);
    case (nib)
      4'd0:    seg7 = 7'b1000000;
      4'd1:    seg7 = 7'b1111001;
      4'd2:    seg7 = 7'b0100100;
      4'd3:    seg7 = 7'b0110000;
      4'd4:    seg7 = 7'b0011001;
      4'd5:    seg7 = 7'b0010010;
      4'd6:    seg7 = 7'b0000010;
      4'd7:    seg7 = 7'b1111000;
      4'd8:    seg7 = 7'b0000000;
      4'd9:    seg7 = 7'b0010000;
      default: seg7 = 7'b1111111;
    endcase
  endfunction

  assign step_c = bus.event_in & ~prev & bus.enable;

  // Ripple carry/borrow across digits; a full ripple naturally yields the wrap value.
  always_comb begin : ripple
    logic carry;
    bcd_step_c = bcd_q;
    at_max_c   = 1'b1;
    at_min_c   = 1'b1;
    carry      = 1'b1;
    for (int i = 0; i < int'(DIGITS); i++) begin
      if (bcd_q[4*i +: 4] != 4'd9) at_max_c = 1'b0;
      if (bcd_q[4*i +: 4] != 4'd0) at_min_c = 1'b0;
      if (carry) begin
        if (bus.down) begin
          if (bcd_q[4*i +: 4] == 4'd0) begin
            bcd_step_c[4*i +: 4] = 4'd9;
          end else begin
            bcd_step_c[4*i +: 4] = bcd_q[4*i +: 4] - 4'd1;
            carry = 1'b0;
          end
        end else begin
          if (bcd_q[4*i +: 4] == 4'd9) begin
            bcd_step_c[4*i +: 4] = 4'd0;
          end else begin
            bcd_step_c[4*i +: 4] = bcd_q[4*i +: 4] + 4'd1;
            carry = 1'b0;
          end
        end
      end
    end
  end

  assign at_limit_c = bus.down ? at_min_c : at_max_c;
  assign hold_c     = SATURATE & at_limit_c;

  // Clear beats step; prev always tracks event_in so an edge during clear is dropped.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      prev    <= 1'b0;
      bcd_q   <= '0;
      count_q <= '0;
      limit_q <= 1'b0;
    end else begin
      prev    <= bus.event_in;
      limit_q <= 1'b0;
      if (bus.clear) begin
        bcd_q   <= '0;
        count_q <= '0;
      end else if (step_c) begin
        limit_q <= at_limit_c;
        if (!hold_c) begin
          bcd_q   <= bcd_step_c;
          count_q <= bus.down ? count_q - BIN_W'(1) : count_q + BIN_W'(1);
        end
      end
    end
  end

  // Display decode, scanning from the most significant digit for leading zeros.
  always_comb begin : decode
`ifdef LEADING_ZERO_BLANK_EN
    logic lead;
    lead = 1'b1;
`endif
    hex_c = '1;
    for (int i = int'(DIGITS) - 1; i >= 0; i--) begin
      hex_c[7*i +: 7] = seg7(bcd_q[4*i +: 4]);
`ifdef LEADING_ZERO_BLANK_EN
      lead = lead & (bcd_q[4*i +: 4] == 4'd0);
      if (lead && (i != 0)) hex_c[7*i +: 7] = 7'b1111111;
`endif
    end
  end

  assign bus.bcd   = bcd_q;
  assign bus.count = count_q;
  assign bus.limit = limit_q;
  assign bus.hex   = hex_c;
endmodule

// File: tb/tb_bcd_event_counter.sv
// Scoreboard bench: three counters (wrap, saturate, 3-digit) share stimulus against a value-level model.
`timescale 1ns/1ps
module tb_bcd_event_counter;
  logic clk = 1'b0;
  logic reset;
  int   n_checks = 0;
  int   n_errors = 0;

  always #5 clk = ~clk;

  bcd_event_counter_if #(.DIGITS(2), .BIN_W(8)) if_w ();
  bcd_event_counter_if #(.DIGITS(2), .BIN_W(8)) if_s ();
  bcd_event_counter_if #(.DIGITS(3), .BIN_W(8)) if_3 ();

  bcd_event_counter #(.DIGITS(2), .BIN_W(8), .SATURATE(1'b0)) u_wrap (.clk(clk), .reset(reset), .bus(if_w));
  bcd_event_counter #(.DIGITS(2), .BIN_W(8), .SATURATE(1'b1)) u_sat  (.clk(clk), .reset(reset), .bus(if_s));
  bcd_event_counter #(.DIGITS(3), .BIN_W(8), .SATURATE(1'b0)) u_d3   (.clk(clk), .reset(reset), .bus(if_3));

  typedef struct {
    int          inst;
    logic [23:0] bcd;
    logic [7:0]  cnt;
    logic        lim;
    logic [41:0] hex;
  } exp_t;

  exp_t  sb[$];
  int    mval[3];
  int    mcnt[3];
  logic  mlim[3];
  logic  mprev;
  int    mdig[3] = '{2, 2, 3};
  bit    msat[3] = '{1'b0, 1'b1, 1'b0};
  string nm[3]   = '{"wrap", "sat", "d3"};

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int pow10(input int n);
    int r = 1;
    for (int i = 0; i < n; i++) r = r * 10;
    return r;
  endfunction

  function automatic logic [6:0] seg_ref(input int d);
    logic [6:0] t [10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
                           7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};
    return t[d];
  endfunction

  function automatic void push_all();
    for (int k = 0; k < 3; k++) begin
      exp_t e;
      e.inst = k;
      e.bcd  = '0;
      e.hex  = '0;
      e.cnt  = 8'(mcnt[k]);
      e.lim  = mlim[k];
      for (int i = 0; i < mdig[k]; i++) begin
        int d = (mval[k] / pow10(i)) % 10;
        e.bcd[4*i +: 4] = 4'(d);
        e.hex[7*i +: 7] = seg_ref(d);
`ifdef LEADING_ZERO_BLANK_EN
        if (i > 0 && mval[k] < pow10(i)) e.hex[7*i +: 7] = 7'b1111111;
`endif
      end
      sb.push_back(e);
    end
  endfunction

  function automatic void model_reset();
    for (int k = 0; k < 3; k++) begin
      mval[k] = 0;
      mcnt[k] = 0;
      mlim[k] = 1'b0;
    end
    mprev = 1'b0;
  endfunction

  function automatic void model_update(input logic ev, input logic en, input logic dn, input logic clr);
    logic st = ev & ~mprev & en;
    for (int k = 0; k < 3; k++) begin
      int maxv = pow10(mdig[k]) - 1;
      mlim[k] = 1'b0;
      if (clr) begin
        mval[k] = 0;
        mcnt[k] = 0;
      end else if (st && !dn) begin
        if (mval[k] == maxv) begin
          mlim[k] = 1'b1;
          if (!msat[k]) begin mval[k] = 0; mcnt[k] = (mcnt[k] + 1) % 256; end
        end else begin
          mval[k] = mval[k] + 1; mcnt[k] = (mcnt[k] + 1) % 256;
        end
      end else if (st && dn) begin
        if (mval[k] == 0) begin
          mlim[k] = 1'b1;
          if (!msat[k]) begin mval[k] = maxv; mcnt[k] = (mcnt[k] + 255) % 256; end
        end else begin
          mval[k] = mval[k] - 1; mcnt[k] = (mcnt[k] + 255) % 256;
        end
      end
    end
    mprev = ev;
    push_all();
  endfunction

  task automatic compare_pending();
    while (sb.size() > 0) begin
      exp_t        e;
      logic [23:0] b;
      logic [7:0]  c;
      logic        l;
      logic [41:0] h;
      e = sb.pop_front();
      case (e.inst)
        0:       begin b = 24'(if_w.bcd); c = if_w.count; l = if_w.limit; h = 42'(if_w.hex); end
        1:       begin b = 24'(if_s.bcd); c = if_s.count; l = if_s.limit; h = 42'(if_s.hex); end
        default: begin b = 24'(if_3.bcd); c = if_3.count; l = if_3.limit; h = 42'(if_3.hex); end
      endcase
      check({nm[e.inst], ".bcd"},   64'(b), 64'(e.bcd));
      check({nm[e.inst], ".count"}, 64'(c), 64'(e.cnt));
      check({nm[e.inst], ".limit"}, 64'(l), 64'(e.lim));
      check({nm[e.inst], ".hex"},   64'(h), 64'(e.hex));
    end
  endtask

  task automatic drive(input logic ev, input logic en, input logic dn, input logic clr);
    if_w.event_in = ev; if_w.enable = en; if_w.down = dn; if_w.clear = clr;
    if_s.event_in = ev; if_s.enable = en; if_s.down = dn; if_s.clear = clr;
    if_3.event_in = ev; if_3.enable = en; if_3.down = dn; if_3.clear = clr;
  endtask

  // One clock: check last edge's results, then drive and predict the next edge.
  task automatic cycle(input logic ev, input logic en, input logic dn, input logic clr);
    @(negedge clk);
    compare_pending();
    drive(ev, en, dn, clr);
    model_update(ev, en, dn, clr);
  endtask

  task automatic pulse(input logic dn, input logic en);
    cycle(1'b1, en, dn, 1'b0);
    cycle(1'b0, en, dn, 1'b0);
  endtask

  task automatic async_reset();
    @(negedge clk);
    compare_pending();
    @(posedge clk);
    #2 reset = 1'b1;
    #1;
    model_reset();
    push_all();
    compare_pending();
    check("async.wrap.count", 64'(if_w.count), 64'd0);
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    drive(1'b0, 1'b1, 1'b0, 1'b0);
    model_reset();
    repeat (2) @(negedge clk);
    push_all();
    compare_pending();
    reset = 1'b0;

    pulse(1'b1, 1'b1);
    cycle(1'b0, 1'b1, 1'b0, 1'b1);

    repeat (12) pulse(1'b0, 1'b1);
    check("basic.bcd", 64'(if_w.bcd), 64'h12);
    check("basic.count", 64'(if_w.count), 64'd12);
    check("basic.hex", 64'(if_w.hex), 64'({7'b1111001, 7'b0100100}));

    repeat (87) pulse(1'b0, 1'b1);
    pulse(1'b0, 1'b1);
    check("wrapup.bcd", 64'(if_w.bcd), 64'h00);
    check("wrapup.count", 64'(if_w.count), 64'd100);
    check("satup.bcd", 64'(if_s.bcd), 64'h99);
    pulse(1'b1, 1'b1);
    check("wrapdn.bcd", 64'(if_w.bcd), 64'h99);
    check("wrapdn.count", 64'(if_w.count), 64'd99);

    cycle(1'b0, 1'b1, 1'b0, 1'b1);
    repeat (10) cycle(1'b1, 1'b1, 1'b0, 1'b0);
    cycle(1'b0, 1'b1, 1'b0, 1'b0);
    pulse(1'b0, 1'b0);
    pulse(1'b0, 1'b1);
    check("edge.count", 64'(if_w.count), 64'd2);

    cycle(1'b0, 1'b1, 1'b0, 1'b1);
    repeat (37) pulse(1'b0, 1'b1);
    check("pre_clear.bcd", 64'(if_w.bcd), 64'h37);
    cycle(1'b1, 1'b1, 1'b0, 1'b1);
    cycle(1'b0, 1'b1, 1'b0, 1'b0);
    check("clear.bcd", 64'(if_w.bcd), 64'h00);
    check("clear.limit", 64'(if_w.limit), 64'd0);

    cycle(1'b0, 1'b1, 1'b0, 1'b1);
    repeat (5) pulse(1'b0, 1'b1);
    async_reset();

    repeat (7) pulse(1'b0, 1'b1);
`ifdef LEADING_ZERO_BLANK_EN
    check("blank7.hex", 64'(if_3.hex), 64'({7'b1111111, 7'b1111111, 7'b1111000}));
`else
    check("blank7.hex", 64'(if_3.hex), 64'({7'b1000000, 7'b1000000, 7'b1111000}));
`endif
    repeat (98) pulse(1'b0, 1'b1);
    check("d3_105.bcd", 64'(if_3.bcd), 64'h105);
    check("d3_105.hex", 64'(if_3.hex), 64'({7'b1111001, 7'b1000000, 7'b0010010}));

    @(negedge clk);
    compare_pending();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/bcd_event_counter.md
# bcd_event_counter

Parametrised, clocked successor to the lab's guess counter. Counts rising edges of a level event input into a DIGITS-wide BCD register with a parallel binary count, supports up/down counting and wrap or saturate at the limits, and drives one active-low seven-segment pattern per digit for the DE1-SoC HEX displays. It sits between the user-input debouncer/synchroniser and the HEX outputs in lab top levels.

## Interface
- DIGITS, 2, number of BCD digits, 1..6.
- BIN_W, 8, width of the binary count output.
- SATURATE, 0: limits wrap. 1: limits hold.
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- clear  in  1  synchronous clear of all counts.
- enable  in  1  when low, edges on event_in are ignored. Edge history is still tracked.
- down  in  1  0 = count up, 1 = count down. Sampled on the same edge as the event.
- event_in  in  1  event level, already synchronised to clk. Each 0->1 transition is one event.
- bcd  out  4*DIGITS  BCD count; digit i is bcd[4i+3:4i], digit 0 is the ones digit.
- count  out  BIN_W  binary count, modulo 2^BIN_W.
- hex  out  7*DIGITS  seven-segment pattern per digit, hex[7i+6:7i], active-low.
- limit  out  1  one-cycle pulse when an event hits a limit (wrap or saturate).

## Operation
- Edge detect: register prev <= event_in every clk. A step occurs when event_in & ~prev & enable.
- Up step:
  - Digit 0 increments.
  - A digit at 9 goes to 0 and carries into the next digit.
  - If all digits are 9 (max = 10^DIGITS-1): with SATURATE=0 all digits go to 0; with SATURATE=1 bcd holds. limit pulses in both cases.
- Down step:
  - Digit 0 decrements.
  - A digit at 0 goes to 9 and borrows from the next digit.
  - If all digits are 0: with SATURATE=0 all digits go to 9; with SATURATE=1 bcd holds. limit pulses in both cases.
- count follows bcd moves:
  - count +1 (up) or -1 (down) modulo 2^BIN_W on every step that changes bcd, including a wrap step.
  - count is unchanged on a saturated (held) step.
- Priority, highest first: reset, clear, step.
  - clear zeroes bcd and count and suppresses limit, even if a step is present.
  - prev still updates during clear, so an edge coinciding with clear is lost rather than deferred.
- Segment codes (bit order gfedcba, active-low): 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000. Any other nibble gives 1111111. Decoding is combinational from the bcd register.
- Digits never hold non-BCD values in normal operation.

## Timing
- Reset values (asynchronous): bcd=0, count=0, limit=0, prev=0. hex shows all digits "0", subject to Configuration.
- Latency: an event edge seen at clk edge k (event_in=1, prev=0) updates bcd, count and limit at edge k. The new values are visible after edge k, and hex follows combinationally in the same cycle.
- limit is high for exactly the one cycle following edge k.
- Back-to-back events need event_in low for at least one sampled clk between highs. An event_in held high counts once.
- When reset deasserts with event_in already high, the first edge after reset counts one event, because prev=0.
- Reset asserted mid-count clears immediately, regardless of clk.

## Configuration
- LEADING_ZERO_BLANK_EN defined:
  - Any digit i>0 that is 0 with all higher digits also 0 displays 1111111 (blank).
  - Digit 0 is always shown.
  - bcd and count are unaffected.
- LEADING_ZERO_BLANK_EN not defined: every digit shows its value, including leading zeros.

## Test plan
- Reset and basic count:
  - Stimulus: DIGITS=2, reset pulse, then 12 single-cycle event_in pulses with enable=1, down=0.
  - Required: bcd=0x12, count=12, hex digit0=0100100, digit1=1111001, limit never high.
- Wrap up and down:
  - Stimulus: SATURATE=0. Count up to 99, one more event; then issue one event with down=1.
  - Required: after the up event, bcd=0x00, count=100, limit pulses for 1 cycle. After the down event, bcd=0x99, count=99, limit pulses.
- Saturate:
  - Stimulus: SATURATE=1, from 0, down=1 event; then reach 99 and send an up event.
  - Required: after the down event, bcd stays 0x00, count stays 0, limit pulses. After the up event, bcd stays 0x99, count=99, limit pulses.
- Edge and enable rules:
  - Stimulus: event_in held high for 10 cycles; then one event with enable=0; then one with enable=1.
  - Required: first phase counts exactly 1; the enable=0 event adds 0; the enable=1 event adds 1. Total=2.
- Clear versus step and asynchronous reset:
  - Stimulus: from bcd=0x37, assert clear on the same edge as an event; later, assert reset between clock edges at count 5.
  - Required: bcd=0 and no limit after the clear edge; all outputs 0 immediately after reset assertion, before the next clk edge.
- Blanking (build with LEADING_ZERO_BLANK_EN):
  - Stimulus: DIGITS=3, count 7.
  - Required: digit2=digit1=1111111, digit0=1111000. At count 105, all three digits are shown, digit1=1000000.
